// File: rtl/uart_rx_param_if.sv
// Ready/valid word channel out of uart_rx_param. It carries the received word together with
// its parity and framing flags.
interface uart_rx_param_if #(
  parameter int DATA_BITS = 8
) ();
  logic [DATA_BITS-1:0] m_data;
  logic                 m_parity_err;
  logic                 m_frame_err;
  logic                 m_valid;
  logic                 m_ready;

  modport master (output m_data, m_parity_err, m_frame_err, m_valid, input m_ready);
  modport slave  (input m_data, m_parity_err, m_frame_err, m_valid, output m_ready);
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: majority-vote oversampling, optional parity, 1-2 stop bits,
// a ready/valid holding register, and overrun/break reporting.
module uart_rx_param #(
  parameter int CLK_DIV    = 4,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rx,
  uart_rx_param_if.master m,
  output logic            overrun,
  output logic            break_det,
  output logic            busy
);
  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int IDX_W  = $clog2(DATA_BITS);
  localparam int HALF   = OVERSAMPLE / 2;

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [TICK_W-1:0] SMP_0     = TICK_W'(HALF - 1);
  localparam logic [TICK_W-1:0] SMP_1     = TICK_W'(HALF);
  localparam logic [TICK_W-1:0] SMP_2     = TICK_W'(HALF + 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_BITS - 1);
  localparam logic [0:0]        STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic              PAR_ODD   = (PARITY == 2);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BRKWAIT
  } state_t;

  state_t               state, state_next;
  logic                 rx_meta, rx_s;
  logic [1:0]           sync_fill;
  logic                 armed;
  logic [DIV_W-1:0]     div_cnt;
  logic [TICK_W-1:0]    tick_cnt;
  logic [2:0]           smp;
  logic [IDX_W-1:0]     idx;
  logic [0:0]           stop_idx;
  logic [DATA_BITS-1:0] data_sr;
  logic                 perr, ferr, hi_seen;
  logic                 tick, bit_end, vote, last_stop, is_break;
  logic                 deliver, brk_now;

  assign busy      = (state != S_IDLE);
  assign tick      = busy && (div_cnt == DIV_LAST);
  assign bit_end   = tick && (tick_cnt == TICK_LAST);
  assign vote      = (smp[0] & smp[1]) | (smp[0] & smp[2]) | (smp[1] & smp[2]);
  assign last_stop = (state == S_STOP) && bit_end && (stop_idx == STOP_LAST);
  // A break is an all-zero frame: data, parity and every stop vote low.
  assign is_break  = (data_sr == '0) && !hi_seen && !vote;

  // NOTE: state and datapath registers use non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  // NOTE: every always_comb output gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    deliver    = 1'b0;
    brk_now    = 1'b0;
    unique case (state)
      S_IDLE:    if (armed && !rx_s) state_next = S_START;
      S_START:   if (bit_end) state_next = vote ? S_IDLE : S_DATA;
      S_DATA:    if (bit_end && idx == IDX_LAST) state_next = (PARITY != 0) ? S_PARITY : S_STOP;
      S_PARITY:  if (bit_end) state_next = S_STOP;
      S_STOP: begin
        if (last_stop) begin
          if (is_break) begin
            brk_now    = 1'b1;
            state_next = S_BRKWAIT;
          end else begin
            deliver    = 1'b1;
            state_next = S_IDLE;
          end
        end
      end
      S_BRKWAIT: if (rx_s) state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_meta        <= 1'b1;
      rx_s           <= 1'b1;
      sync_fill      <= '0;
      armed          <= 1'b0;
      div_cnt        <= '0;
      tick_cnt       <= '0;
      smp            <= '0;
      idx            <= '0;
      stop_idx       <= '0;
      data_sr        <= '0;
      perr           <= 1'b0;
      ferr           <= 1'b0;
      hi_seen        <= 1'b0;
      m.m_data       <= '0;
      m.m_parity_err <= 1'b0;
      m.m_frame_err  <= 1'b0;
      m.m_valid      <= 1'b0;
      overrun        <= 1'b0;
      break_det      <= 1'b0;
    end else begin
      rx_meta   <= rx;
      rx_s      <= rx_meta;
      // Arm only on a high that really came through both synchroniser stages,
      // not on their reset value.
      sync_fill <= {sync_fill[0], 1'b1};
      if (sync_fill[1] && rx_s) armed <= 1'b1;

      if (!busy) begin
        div_cnt  <= '0;
        tick_cnt <= '0;
      end else if (tick) begin
        div_cnt  <= '0;
        tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;
      end else begin
        div_cnt  <= div_cnt + 1'b1;
      end

      if (tick) begin
        if (tick_cnt == SMP_0) smp[0] <= rx_s;
        if (tick_cnt == SMP_1) smp[1] <= rx_s;
        if (tick_cnt == SMP_2) smp[2] <= rx_s;
      end

      if (bit_end) begin
        unique case (state)
          S_START: begin
            idx      <= '0;
            stop_idx <= '0;
            data_sr  <= '0;
            perr     <= 1'b0;
            ferr     <= 1'b0;
            hi_seen  <= 1'b0;
          end
          S_DATA: begin
            data_sr[idx] <= vote;
            idx          <= idx + 1'b1;
          end
          S_PARITY: begin
            perr    <= (^data_sr ^ vote) ^ PAR_ODD;
            hi_seen <= hi_seen | vote;
          end
          S_STOP: begin
            ferr     <= ferr | ~vote;
            hi_seen  <= hi_seen | vote;
            stop_idx <= stop_idx + 1'b1;
          end
          default: ;
        endcase
      end

      overrun   <= deliver && m.m_valid && !m.m_ready;
      break_det <= brk_now;
      if (deliver && (!m.m_valid || m.m_ready)) begin
        m.m_data       <= data_sr;
        m.m_parity_err <= perr;
        m.m_frame_err  <= ferr | ~vote;
        m.m_valid      <= 1'b1;
      end else if (m.m_valid && m.m_ready) begin
        m.m_valid <= 1'b0;
      end
    end
  end
endmodule
